// File: rtl/mux_pipe.sv
// mux_pipe: N:1 channel multiplexer feeding a STAGES-deep valid/ready
// register pipeline. Empty stages fill even while the output is stalled,
// so the pipe holds up to STAGES beats.
//
// Optional build macro MUX_PIPE_SEL_CHECK_EN: adds a sticky 'err' output.
// A beat whose sel is >= NUM_IN is then consumed without entering the pipe
// as a valid beat. Without the macro such a beat carries channel 0 data and
// its raw sel value.
module mux_pipe #(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 2,
  parameter int STAGES = 2,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_PIPE_SEL_CHECK_EN
  ,
  output logic                    err
`endif
);

  logic [WIDTH-1:0]  mux_out;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [SEL_W-1:0]  sel_q  [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] open_s;
  logic              accept;
  logic              beat_ok;

  // Channel select; any sel with no matching channel falls back to channel 0
  always_comb begin
    mux_out = in_data[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      if (sel == k[SEL_W-1:0]) mux_out = in_data[k*WIDTH +: WIDTH];
    end
  end

  // A stage can advance when it or any stage after it is empty, or the
  // consumer is taking the last beat. Written as a reduction over the tail
  // of the valid vector to avoid a combinational chain through open_s.
  for (genvar i = 0; i < STAGES; i++) begin : g_open
    assign open_s[i] = out_ready || !(&v_q[STAGES-1:i]);
  end

  assign in_ready = open_s[0];
  assign accept   = in_valid && open_s[0];

`ifdef MUX_PIPE_SEL_CHECK_EN
  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);
  assign beat_ok = ({1'b0, sel} < NUM_IN_L);
`else
  assign beat_ok = 1'b1;
`endif

  // Pipeline registers: open stages shift forward, closed stages hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
        sel_q[i]  <= '0;
      end
    end else begin
      if (open_s[0]) begin
        v_q[0] <= accept && beat_ok;
        if (accept && beat_ok) begin
          data_q[0] <= mux_out;
          sel_q[0]  <= sel;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (open_s[i]) begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) begin
            data_q[i] <= data_q[i-1];
            sel_q[i]  <= sel_q[i-1];
          end
        end
      end
    end
  end

`ifdef MUX_PIPE_SEL_CHECK_EN
  // Sticky flag for any consumed beat that had an out-of-range sel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (accept && !beat_ok) err <= 1'b1;
  end
`endif

  assign out_data  = data_q[STAGES-1];
  assign out_sel   = sel_q[STAGES-1];
  assign out_valid = v_q[STAGES-1];

endmodule
